// File: rtl/paddle_renderer_pkg.sv
// Shared types for the paddle renderer: FSM encoding, colour width and move decoding.
package paddle_renderer_pkg;

    localparam int unsigned COLOUR_W = 3;

    typedef enum logic [1:0] {StIdle, StErase, StDraw, StDone} state_e;

    typedef enum logic [1:0] {MoveHold, MoveLeft, MoveRight} move_e;

    // Both directions at once, or no movement tick, means the paddle holds.
    function automatic move_e decode_move(logic left, logic right, logic enable);
        if (!enable || (left == right)) return MoveHold;
        return left ? MoveLeft : MoveRight;
    endfunction

endpackage

// File: rtl/paddle_renderer_if.sv
// Control inputs and pixel-write bus between game control, the renderer and the VGA arbiter.
interface paddle_renderer_if
    import paddle_renderer_pkg::*;
#(
    parameter int unsigned X_W = 10
) ();

    logic                left;
    logic                right;
    logic                enable;
    logic                draw;
    logic [X_W-1:0]      x;
    logic [X_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                writeEn;
    logic                busy;
    logic                done;
    logic [X_W-1:0]      pos_x;

    modport master (
        output left, right, enable, draw,
        input  x, y, colour, writeEn, busy, done, pos_x
    );

    modport slave (
        input  left, right, enable, draw,
        output x, y, colour, writeEn, busy, done, pos_x
    );

endinterface

// File: rtl/paddle_renderer_rect_scanner.sv
// Row-major PLAT_W x PLAT_H rectangle scanner (qx fastest); shared with the brick eraser.
module paddle_renderer_rect_scanner #(
    parameter int unsigned PLAT_W = 20,
    parameter int unsigned PLAT_H = 2,
    parameter int unsigned QX_W   = (PLAT_W > 1) ? $clog2(PLAT_W) : 1,
    parameter int unsigned QY_W   = (PLAT_H > 1) ? $clog2(PLAT_H) : 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            clear,
    input  logic            advance,
    output logic [QX_W-1:0] qx,
    output logic [QY_W-1:0] qy,
    output logic            last
);

    localparam logic [QX_W-1:0] QxLast = QX_W'(PLAT_W - 1);
    localparam logic [QY_W-1:0] QyLast = QY_W'(PLAT_H - 1);

    logic [QX_W-1:0] qx_q;
    logic [QY_W-1:0] qy_q;

    assign last = (qx_q == QxLast) && (qy_q == QyLast);
    assign qx   = qx_q;
    assign qy   = qy_q;

    always_ff @(posedge clk) begin
        if (!resetn || start || clear) begin
            qx_q <= '0;
            qy_q <= '0;
        end else if (advance) begin
            if (qx_q == QxLast) begin
                qx_q <= '0;
                qy_q <= last ? '0 : qy_q + QY_W'(1);
            end else begin
                qx_q <= qx_q + QX_W'(1);
            end
        end
    end

endmodule

// File: rtl/paddle_renderer.sv
// Paddle position tracker and erase-then-draw pixel sequencer feeding the VGA write arbiter.
module paddle_renderer
    import paddle_renderer_pkg::*;
#(
    parameter int unsigned         X_W       = 10,
    parameter int unsigned         PLAT_W    = 20,
    parameter int unsigned         PLAT_H    = 2,
    parameter int unsigned         SPEED     = 1,
    parameter int unsigned         X_MIN     = 0,
    parameter int unsigned         X_MAX     = 159,
    parameter int unsigned         X_INIT    = 32,
    parameter int unsigned         Y_POS     = 110,
    parameter logic [COLOUR_W-1:0] FG_COLOUR = 3'b100,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
    input  logic               clk,
    input  logic               resetn,
    paddle_renderer_if.slave   bus
);

    localparam int unsigned QX_W = (PLAT_W > 1) ? $clog2(PLAT_W) : 1;
    localparam int unsigned QY_W = (PLAT_H > 1) ? $clog2(PLAT_H) : 1;

    localparam logic [X_W:0] SpeedExt = (X_W + 1)'(SPEED);
    localparam logic [X_W:0] XMinExt  = (X_W + 1)'(X_MIN);
    localparam logic [X_W:0] XMaxBase = (X_W + 1)'(X_MAX - PLAT_W + 1);

    state_e          state_q, state_d;
    logic [X_W-1:0]  pos_x_q, pos_x_d;
    logic [X_W-1:0]  draw_x_q, draw_x_d;
    logic [X_W-1:0]  drawn_x_q, drawn_x_d;
    logic            drawn_valid_q, drawn_valid_d;

    logic            scan_start, scan_clear, scan_advance, scan_last;
    logic [QX_W-1:0] qx;
    logic [QY_W-1:0] qy;
    logic [X_W-1:0]  base_x;
    logic [X_W:0]    pos_ext, pos_dec, pos_inc;

    paddle_renderer_rect_scanner #(
        .PLAT_W (PLAT_W),
        .PLAT_H (PLAT_H)
    ) u_scanner (
        .clk     (clk),
        .resetn  (resetn),
        .start   (scan_start),
        .clear   (scan_clear),
        .advance (scan_advance),
        .qx      (qx),
        .qy      (qy),
        .last    (scan_last)
    );

    // One extra bit so a step below zero shows up as a borrow and clamps.
    always_comb begin
        pos_ext = {1'b0, pos_x_q};
        pos_dec = pos_ext - SpeedExt;
        pos_inc = pos_ext + SpeedExt;
    end

    always_comb begin
        state_d       = state_q;
        pos_x_d       = pos_x_q;
        draw_x_d      = draw_x_q;
        drawn_x_d     = drawn_x_q;
        drawn_valid_d = drawn_valid_q;
        scan_start    = 1'b0;
        scan_clear    = 1'b0;
        scan_advance  = 1'b0;
        base_x        = '0;
        bus.writeEn   = 1'b0;
        bus.colour    = '0;
        bus.done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A draw request wins over a same-cycle move; the move is dropped.
                if (bus.draw) begin
                    draw_x_d   = pos_x_q;
                    scan_start = 1'b1;
                    state_d    = (drawn_valid_q && (drawn_x_q != pos_x_q)) ? StErase : StDraw;
                end else begin
                    unique case (decode_move(bus.left, bus.right, bus.enable))
                        MoveLeft: begin
                            pos_x_d = (pos_dec[X_W] || (pos_dec < XMinExt)) ?
                                      XMinExt[X_W-1:0] : pos_dec[X_W-1:0];
                        end
                        MoveRight: begin
                            pos_x_d = (pos_inc > XMaxBase) ? XMaxBase[X_W-1:0] : pos_inc[X_W-1:0];
                        end
                        default: pos_x_d = pos_x_q;
                    endcase
                end
            end
            StErase: begin
                bus.writeEn  = 1'b1;
                bus.colour   = BG_COLOUR;
                base_x       = drawn_x_q;
                scan_advance = 1'b1;
                if (scan_last) begin
                    scan_clear = 1'b1;
                    state_d    = StDraw;
                end
            end
            StDraw: begin
                bus.writeEn  = 1'b1;
                bus.colour   = FG_COLOUR;
                base_x       = draw_x_q;
                scan_advance = 1'b1;
                if (scan_last) begin
                    drawn_x_d     = draw_x_q;
                    drawn_valid_d = 1'b1;
                    state_d       = StDone;
                end
            end
            StDone: begin
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy  = (state_q != StIdle);
        bus.pos_x = pos_x_q;
        if (bus.writeEn) begin
            bus.x = base_x + X_W'(qx);
            bus.y = X_W'(Y_POS) + X_W'(qy);
        end else begin
            bus.x = '0;
            bus.y = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= StIdle;
            pos_x_q       <= X_W'(X_INIT);
            draw_x_q      <= '0;
            drawn_x_q     <= '0;
            drawn_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_x_q       <= pos_x_d;
            draw_x_q      <= draw_x_d;
            drawn_x_q     <= drawn_x_d;
            drawn_valid_q <= drawn_valid_d;
        end
    end

endmodule

// File: doc/paddle_renderer.md
Name: paddle_renderer

Overview:
Parametrised successor to the single-row platform drawer. Holds the paddle's horizontal position and moves it by a configurable step with clamped bounds. On each draw request it erases the previously drawn rectangle in background colour, then draws the PLAT_W x PLAT_H rectangle at the current position, one pixel per cycle. It sits between game control (left/right/enable/draw) and the shared VGA pixel-write arbiter.

Parameters:
X_W, 10, width of x/y pixel coordinates
PLAT_W, 20, paddle width in pixels (>=1)
PLAT_H, 2, paddle height in pixels (>=1)
SPEED, 1, pixels moved per enabled move cycle
X_MIN, 0, leftmost legal base x
X_MAX, 159, rightmost legal pixel column; base x max = X_MAX-PLAT_W+1
X_INIT, 32, base x after reset
Y_POS, 110, top row of paddle
FG_COLOUR, 3'b100, paddle colour
BG_COLOUR, 3'b000, erase colour

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
left  in  1  move-left request
right  in  1  move-right request
enable  in  1  movement tick; a move happens only on cycles where this is high
draw  in  1  start erase/draw sequence (level-sampled in IDLE)
x  out  X_W  pixel x
y  out  X_W  pixel y
colour  out  3  pixel colour
writeEn  out  1  pixel write strobe
busy  out  1  high while in ERASE, DRAW or DONE
done  out  1  one-cycle pulse at end of sequence
pos_x  out  X_W  current base x (debug/collision)

Behaviour:
- One clock (clk); reset synchronous, active-low (resetn). Reset: state=IDLE, pos_x=X_INIT, drawn_valid=0, counters=0, writeEn=0, busy=0, done=0, x=0, y=0, colour=0.
- States: IDLE, ERASE, DRAW, DONE.
- IDLE, draw=1: latch draw_x=pos_x. If drawn_valid && drawn_x!=draw_x, go to ERASE; otherwise go to DRAW. Counters are cleared.
- ERASE: scans the rectangle at drawn_x in BG_COLOUR. After the last pixel, clear counters and go to DRAW.
- DRAW: scans the rectangle at draw_x in FG_COLOUR. After the last pixel, set drawn_x=draw_x, drawn_valid=1, and go to DONE.
- DONE: done=1 for exactly one cycle, writeEn=0; next state is IDLE.
- Scan: row-major, qx fastest. qx runs 0..PLAT_W-1, qy runs 0..PLAT_H-1. The last pixel is qx==PLAT_W-1 && qy==PLAT_H-1.
- Outputs are combinational from the state and counter registers. writeEn=1 in ERASE/DRAW; x=base+qx; y=Y_POS+qy. In IDLE/DONE, x, y and colour are 0.
- Latency: draw sampled at edge k → first pixel valid in the cycle after edge k. A draw-only sequence is PLAT_W*PLAT_H write cycles plus 1 DONE cycle. With erase it is 2*PLAT_W*PLAT_H write cycles plus 1.
- Movement (IDLE only, enable=1, draw=0):
  - left&!right: pos_x = max(X_MIN, pos_x-SPEED).
  - right&!left: pos_x = min(X_MAX-PLAT_W+1, pos_x+SPEED).
  - Both or neither: hold.
  - Compute in X_W+1 bits so a subtraction below zero clamps instead of wrapping.
- Simultaneous draw and move in IDLE: draw wins, the move is dropped, and draw_x is the pre-move position.
- Moves and draws requested while busy are ignored. There is no queuing.
- Reset mid-sequence: outputs drop on the next cycle; drawn_valid=0, so the next draw performs no erase.

Decomposition:
- macros.v: PLATSIZE, PLATY, SCREEN_XMAX, FG/BG colour constants, and the state encoding localparams used by the top-level write arbiter.
- Sub-module rect_scanner: start, clear, advance, qx, qy, last; parameters PLAT_W and PLAT_H. It is reused later by the brick eraser.

Test Plan:
- Reset, then draw → 40 writes: colour 100, x 32..51 for y=110, then 32..51 for y=111; no erase; done pulses one cycle after the last write; busy drops the cycle after done.
- enable+right for 3 cycles, then draw → pos_x=35. First 40 writes are colour 000 at x 32..51; next 40 writes are colour 100 at x 35..54.
- Clamps with SPEED=2: pos 1 + left → 0; pos 0 + left → 0; pos 140 + right → 140. Redraw at the unchanged position produces no erase writes.
- left&right&enable → pos_x unchanged. enable=0 with right → unchanged. draw and right&enable in the same cycle → draws at the old x, pos_x unchanged.
- Move and draw pulses during busy → ignored: pos_x constant, exactly one done.
- Reset asserted at write 10 of DRAW → writeEn=0 on the next cycle, pos_x=32. The next draw issues 40 writes with no erase.
